// File: rtl/secuenciador_memoria_instrucciones.sv
// Instruction-memory sequencer: arbitrates a byte-wide port between a program
// loader and a fetch requester, and assembles big-endian 32-bit fetch words.
module secuenciador_memoria_instrucciones #(
    parameter int ADDR_W        = 8,
    parameter bit LOAD_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_dir,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_error,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_dir,
    input  logic [7:0]        load_byte,
    output logic [ADDR_W-1:0] mem_dir,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        LEER,
        ENTREGAR
    } estado_t;

    localparam logic [32:0] MEM_SIZE = 33'd1 << ADDR_W;

    estado_t           estado;
    estado_t           estado_d;
    logic [ADDR_W-1:0] base;
    logic [1:0]        cnt;
    logic [23:0]       word;
    logic              load_sel;
    logic              fetch_sel;
    logic              load_in_range;
    logic              fetch_bad;

    assign load_sel      = (estado == IDLE) && load_valid
                           && (LOAD_PRIORITY || !req_valid);
    assign fetch_sel     = (estado == IDLE) && req_valid && !load_sel;
    assign load_in_range = {1'b0, load_dir} < MEM_SIZE;
    // Anything past the last full word, or not word-aligned, is an error.
    assign fetch_bad     = (req_dir[1:0] != 2'b00)
                           || ({1'b0, req_dir} > MEM_SIZE - 33'd4);

    assign req_ready  = !rst && fetch_sel;
    assign load_ready = !rst && load_sel;
    assign mem_we     = !rst && load_sel && load_in_range;
    assign resp_valid = (estado == ENTREGAR);

    always_comb begin
        mem_dir   = '0;
        mem_wdata = 8'h00;
        if (load_sel) begin
            mem_dir   = load_dir[ADDR_W-1:0];
            mem_wdata = load_byte;
        end else if (estado == LEER) begin
            mem_dir = base + ADDR_W'(cnt);
        end
    end

    always_comb begin
        estado_d = estado;
        unique case (estado)
            IDLE: begin
                if (fetch_sel) begin
                    estado_d = fetch_bad ? ENTREGAR : LEER;
                end
            end
            LEER: begin
                if (cnt == 2'd3) begin
                    estado_d = ENTREGAR;
                end
            end
            ENTREGAR: begin
                if (resp_ready) begin
                    estado_d = IDLE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base       <= '0;
            cnt        <= 2'd0;
            word       <= 24'h0;
            resp_data  <= 32'h0;
            resp_error <= 1'b0;
        end else if (fetch_sel) begin
            base <= req_dir[ADDR_W-1:0];
            cnt  <= 2'd0;
            if (fetch_bad) begin
                resp_data  <= 32'h0;
                resp_error <= 1'b1;
            end
        end else if (estado == LEER) begin
            word <= {word[15:0], mem_rdata};
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                resp_data  <= {word, mem_rdata};
                resp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_memoria_instrucciones.sv
// Bench for the instruction-memory sequencer: behavioural byte memory,
// scoreboard of expected fetch words, and a second instance for fetch priority.
module tb_secuenciador_memoria_instrucciones;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_dir;
    logic        resp_ready;
    logic        load_valid;
    logic [31:0] load_dir;
    logic [7:0]  load_byte;

    logic        req_ready, resp_valid, resp_error, load_ready, mem_we;
    logic [31:0] resp_data;
    logic [7:0]  mem_dir, mem_wdata, mem_rdata;

    logic        req_ready0, resp_valid0, resp_error0, load_ready0, mem_we0;
    logic [31:0] resp_data0;
    logic [7:0]  mem_dir0, mem_wdata0, mem_rdata0;

    logic [7:0] mem [256];
    logic [7:0] mem0 [256];
    logic [7:0] model [256];

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    secuenciador_memoria_instrucciones #(
        .ADDR_W(8), .LOAD_PRIORITY(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_dir(load_dir), .load_byte(load_byte),
        .mem_dir(mem_dir), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    secuenciador_memoria_instrucciones #(
        .ADDR_W(8), .LOAD_PRIORITY(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready0), .req_dir(req_dir),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_data(resp_data0), .resp_error(resp_error0),
        .load_valid(load_valid), .load_ready(load_ready0),
        .load_dir(load_dir), .load_byte(load_byte),
        .mem_dir(mem_dir0), .mem_we(mem_we0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    assign mem_rdata  = mem[mem_dir];
    assign mem_rdata0 = mem0[mem_dir0];

    always @(posedge clk) begin
        if (mem_we) mem[mem_dir] <= mem_wdata;
        if (mem_we0) mem0[mem_dir0] <= mem_wdata0;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] d);
        logic [7:0] a;
        a = d[7:0];
        return {model[a], model[a + 8'd1], model[a + 8'd2], model[a + 8'd3]};
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_load(input logic [31:0] dir, input logic [7:0] b);
        load_dir   = dir;
        load_byte  = b;
        load_valid = 1'b1;
        @(negedge clk);
        check("load_ready", 64'(load_ready), 64'd1);
        check("load_we", 64'(mem_we), 64'(dir < 32'd256));
        if (dir < 32'd256) model[dir[7:0]] = b;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] dir, input int hold);
        resp_t e;
        resp_t g;
        logic  bad;
        int    k;
        bad = (dir[1:0] != 2'b00) || (dir > 32'd252);
        req_dir   = dir;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'd1);
        e.err  = bad;
        e.data = bad ? 32'h0 : model_word(dir);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 20);
        check("latency", 64'(k), bad ? 64'd1 : 64'd5);
        g = sb.pop_front();
        check("resp_data", 64'(resp_data), 64'(g.data));
        check("resp_error", 64'(resp_error), 64'(g.err));
        if (hold > 0) begin
            load_valid = 1'b1;
            load_dir   = 32'd0;
            req_valid  = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 64'(resp_valid), 64'd1);
                check("hold_data", 64'(resp_data), 64'(g.data));
                check("hold_rdy", 64'({req_ready, load_ready, mem_we}), 64'd0);
            end
            load_valid = 1'b0;
            req_valid  = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("resp_drop", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    seen;
        bit    got1;
        bit    got0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            mem0[i]  = 8'h00;
            model[i] = 8'h00;
        end
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_dir    = 32'd0;
        resp_ready = 1'b0;
        load_valid = 1'b1;
        load_dir   = 32'd5;
        load_byte  = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_data", 64'(resp_data), 64'd0);
        check("rst_error", 64'(resp_error), 64'd0);
        check("rst_rdy", 64'({req_ready, load_ready, mem_we}), 64'd0);
        req_valid  = 1'b0;
        load_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        do_load(32'd0, 8'h01);
        do_load(32'd1, 8'h4A);
        do_load(32'd2, 8'h18);
        do_load(32'd3, 8'h20);
        do_fetch(32'd0, 0);

        do_fetch(32'd2, 0);
        check("untouched", 64'({mem[0], mem[1], mem[2], mem[3]}),
              64'h014A1820);

        do_fetch(32'd256, 0);
        do_load(32'd252, 8'h11);
        do_load(32'd253, 8'h22);
        do_load(32'd254, 8'h33);
        do_load(32'd255, 8'h44);
        do_fetch(32'd252, 3);
        do_load(32'd300, 8'hEE);
        check("oor_drop", 64'(mem[44]), 64'(model[44]));
        do_fetch(32'd253, 0);

        // Reset during the third read beat.
        req_dir   = 32'd4;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_rdy", 64'({req_ready, load_ready, mem_we}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst_no_resp", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        do_fetch(32'd0, 0);

        // Same-cycle conflict: dut favours the loader, dut0 the fetch.
        load_valid = 1'b1;
        load_dir   = 32'd8;
        load_byte  = 8'h5A;
        req_valid  = 1'b1;
        req_dir    = 32'd0;
        @(negedge clk);
        check("lp1_load", 64'({load_ready, req_ready}), 64'b10);
        check("lp0_fetch", 64'({load_ready0, req_ready0, mem_we0}), 64'b010);
        model[8] = 8'h5A;
        @(posedge clk);
        #1 load_valid = 1'b0;
        @(negedge clk);
        check("lp1_fetch_next", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        resp_ready = 1'b1;
        got1 = 1'b0;
        got0 = 1'b0;
        for (int i = 0; i < 20 && !(got1 && got0); i++) begin
            @(negedge clk);
            if (resp_valid && !got1) begin
                check("lp1_resp", 64'(resp_data), 64'h014A1820);
                got1 = 1'b1;
            end
            if (resp_valid0 && !got0) begin
                check("lp0_resp", 64'(resp_data0), 64'h014A1820);
                got0 = 1'b1;
            end
        end
        check("both_resp", 64'({got1, got0}), 64'b11);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        load_valid = 1'b1;
        @(negedge clk);
        check("lp0_load_after", 64'({load_ready0, mem_we0}), 64'b11);
        @(posedge clk);
        #1 load_valid = 1'b0;
        check("lp0_mem", 64'(mem0[8]), 64'h5A);
        check("lp1_mem", 64'(mem[8]), 64'(model[8]));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
